// File: rtl/nios2_mult_pkg.sv
// nios2_mult_pkg: shared types and helpers for the pipelined Nios II multiplier.
//   mult_op_e      - operation encoding carried on in_op (MUL, MULXUU, MULXSU, MULXSS)
//   slice_sign_t   - signedness of the high operand slices for one operation
//   op_slice_sign  - derives slice_sign_t from an operation
package nios2_mult_pkg;

  typedef enum logic [1:0] {
    OpMul    = 2'd0,
    OpMulxuu = 2'd1,
    OpMulxsu = 2'd2,
    OpMulxss = 2'd3
  } mult_op_e;

  typedef struct packed {
    logic a_hi_signed;
    logic b_hi_signed;
  } slice_sign_t;

  // Low slices are always zero-extended, so only the high slices need a sign flag.
  // MUL uses unsigned extension: the low product word does not depend on signedness.
  function automatic slice_sign_t op_slice_sign(mult_op_e op);
    slice_sign_t s;
    s.a_hi_signed = (op == OpMulxsu) || (op == OpMulxss);
    s.b_hi_signed = (op == OpMulxss);
    return s;
  endfunction

endpackage

// File: rtl/nios2_mult_pipe_if.sv
// nios2_mult_pipe_if: request/response bundle of the pipelined multiplier.
//   in_valid/in_ready    - request handshake; in_op, in_a, in_b, in_tag are the payload
//   out_valid/out_ready  - response handshake; out_result, out_tag are the payload
// Modports: master (producer/consumer side, e.g. the pipeline or a bench), slave (multiplier).
interface nios2_mult_pipe_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_op;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [TAG_W-1:0]  out_tag;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );
endinterface

// File: rtl/nios2_mult_slice.sv
// nios2_mult_slice: one registered signed (SliceW+1)x(SliceW+1) multiplier.
//   clk_i  - clock
//   rst_ni - asynchronous active-low reset, clears the product register
//   en_i   - load enable for the product register
//   a_i    - signed operand slice, already extended to SliceW+1 bits
//   b_i    - signed operand slice, already extended to SliceW+1 bits
//   p_o    - registered signed product, 2*SliceW+2 bits
module nios2_mult_slice #(
  parameter int unsigned SliceW = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       en_i,
  input  logic signed [SliceW:0]     a_i,
  input  logic signed [SliceW:0]     b_i,
  output logic signed [2*SliceW+1:0] p_o
);

  logic signed [2*SliceW+1:0] p_d;
  logic signed [2*SliceW+1:0] p_q;

  assign p_d = a_i * b_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      p_q <= '0;
    end else if (en_i) begin
      p_q <= p_d;
    end
  end

  assign p_o = p_q;

endmodule

// File: rtl/nios2_mult_pipe.sv
// nios2_mult_pipe: two-stage pipelined integer multiplier for the Nios II datapath.
//   clk      - clock, rising edge
//   reset_n  - asynchronous active-low reset; flushes both stages
//   bus      - nios2_mult_pipe_if.slave: valid/ready request (op, a, b, tag) and
//              valid/ready response (result, tag)
// S1 registers four slice partial products plus op/tag; S2 sums them into a 2*DATA_W
// product and registers the selected word. DATA_W must be even and >= 8.
// Build option: define NIOS2_MULT_PIPE_MULX_EN to build the high-word ops (MULXUU/MULXSU/
// MULXSS). Without it the aH*bH multiplier is omitted, in_op is ignored and every op
// returns the low product word.
module nios2_mult_pipe
  import nios2_mult_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 5
) (
  input logic               clk,
  input logic               reset_n,
  nios2_mult_pipe_if.slave  bus
);

  localparam int unsigned SliceW = DATA_W / 2;
  localparam int unsigned ProdW  = 2 * SliceW + 2;
  localparam int unsigned SumW   = 2 * DATA_W;

  // Handshake: a stage advances when it is empty or its successor advances.
  logic s1_valid_q, s1_valid_d;
  logic out_valid_q, out_valid_d;
  logic s1_adv, s2_adv, s1_load, s2_load;

  assign s2_adv       = !out_valid_q || bus.out_ready;
  assign s1_adv       = !s1_valid_q || s2_adv;
  assign bus.in_ready = s1_adv;
  // Payload registers only load on a real transfer; a bubble leaves stale data in place.
  assign s1_load      = s1_adv && bus.in_valid;
  assign s2_load      = s2_adv && s1_valid_q;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    out_valid_d = out_valid_q;
    if (s1_adv) s1_valid_d = bus.in_valid;
    if (s2_adv) out_valid_d = s1_valid_q;
  end

  // Operand slicing and extension to SliceW+1 bits.
  slice_sign_t          slice_sign;
  logic signed [SliceW:0] a_lo, a_hi, b_lo, b_hi;

`ifdef NIOS2_MULT_PIPE_MULX_EN
  assign slice_sign = op_slice_sign(mult_op_e'(bus.in_op));
`else
  assign slice_sign = '0;
`endif

  assign a_lo = {1'b0, bus.in_a[SliceW-1:0]};
  assign b_lo = {1'b0, bus.in_b[SliceW-1:0]};
  assign a_hi = {slice_sign.a_hi_signed & bus.in_a[DATA_W-1], bus.in_a[DATA_W-1:SliceW]};
  assign b_hi = {slice_sign.b_hi_signed & bus.in_b[DATA_W-1], bus.in_b[DATA_W-1:SliceW]};

  // S1: registered partial products.
  logic signed [ProdW-1:0] p_ll, p_lh, p_hl, p_hh;

  nios2_mult_slice #(.SliceW(SliceW)) u_slice_ll (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .en_i   (s1_load),
    .a_i    (a_lo),
    .b_i    (b_lo),
    .p_o    (p_ll)
  );

  nios2_mult_slice #(.SliceW(SliceW)) u_slice_lh (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .en_i   (s1_load),
    .a_i    (a_lo),
    .b_i    (b_hi),
    .p_o    (p_lh)
  );

  nios2_mult_slice #(.SliceW(SliceW)) u_slice_hl (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .en_i   (s1_load),
    .a_i    (a_hi),
    .b_i    (b_lo),
    .p_o    (p_hl)
  );

`ifdef NIOS2_MULT_PIPE_MULX_EN
  nios2_mult_slice #(.SliceW(SliceW)) u_slice_hh (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .en_i   (s1_load),
    .a_i    (a_hi),
    .b_i    (b_hi),
    .p_o    (p_hh)
  );

  mult_op_e s1_op_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_op_q <= OpMul;
    end else if (s1_load) begin
      s1_op_q <= mult_op_e'(bus.in_op);
    end
  end
`else
  // aH*bH only reaches bits >= DATA_W, which the low-word-only build never returns.
  assign p_hh = '0;
`endif

  logic [TAG_W-1:0] s1_tag_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (s1_load) s1_tag_q <= bus.in_tag;
    end
  end

  // S2: sum the partials in 2*DATA_W bits with wrap-around.
  function automatic logic [SumW-1:0] sext_prod(logic [ProdW-1:0] p);
    return {{(SumW - ProdW){p[ProdW-1]}}, p};
  endfunction

  logic [SumW-1:0]   sum;
  logic [DATA_W-1:0] result_d;

  assign sum = sext_prod(p_ll)
             + ((sext_prod(p_lh) + sext_prod(p_hl)) << SliceW)
             + (sext_prod(p_hh) << DATA_W);

`ifdef NIOS2_MULT_PIPE_MULX_EN
  assign result_d = (s1_op_q == OpMul) ? sum[DATA_W-1:0] : sum[SumW-1:DATA_W];
`else
  assign result_d = sum[DATA_W-1:0];
  logic unused_hi;
  assign unused_hi = ^{bus.in_op, sum[SumW-1:DATA_W]};
`endif

  logic [DATA_W-1:0] out_result_q;
  logic [TAG_W-1:0]  out_tag_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      if (s2_load) begin
        out_result_q <= result_d;
        out_tag_q    <= s1_tag_q;
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_tag    = out_tag_q;

endmodule

// File: tb/tb_nios2_mult_pipe.sv
// tb_nios2_mult_pipe: scoreboard bench for nios2_mult_pipe (DATA_W=32, TAG_W=5).
// Works in both builds; expected values follow NIOS2_MULT_PIPE_MULX_EN.
module tb_nios2_mult_pipe;
  localparam int unsigned DW = 32;
  localparam int unsigned TW = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  nios2_mult_pipe_if #(.DATA_W(DW), .TAG_W(TW)) bus ();

  nios2_mult_pipe #(.DATA_W(DW), .TAG_W(TW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [31:0] result;
    logic [4:0]  tag;
    bit          chk_lat;
    int unsigned due;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] exp_mulx;
    logic [31:0] exp_lo;
  } vec_t;

  // Hand-computed: full-feature high/low word, and the low-word-only build result.
  vec_t vecs [8] = '{
    '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'h0000_0001, 32'h0000_0001},
    '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFE, 32'h0000_0001},
    '{2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFF, 32'h0000_0001},
    '{2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'h0000_0000, 32'h0000_0001},
    '{2'd3, 32'h8000_0000, 32'h8000_0000, 5'd9,  32'h4000_0000, 32'h0000_0000},
    '{2'd2, 32'h8000_0000, 32'h0000_0002, 5'd10, 32'hFFFF_FFFF, 32'h0000_0000},
    '{2'd1, 32'h0001_0000, 32'h0001_0000, 5'd11, 32'h0000_0001, 32'h0000_0000},
    '{2'd0, 32'h0001_2345, 32'h0000_1000, 5'd12, 32'h1234_5000, 32'h1234_5000}
  };

  exp_t        sb [$];
  int          checks = 0;
  int          failures = 0;
  int          pushed = 0;
  int          popped = 0;
  int          flushed = 0;
  int unsigned cyc = 0;
  logic [31:0] cur_exp = '0;
  bit          cur_chk = 1'b0;
  bit          or_level = 1'b1;
  int          hold_cnt = 0;
  bit          saw_bp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Reference: full 64-bit product with per-op operand extension, then word select.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] ax, bx, p;
    ax = {32'b0, a};
    bx = {32'b0, b};
`ifdef NIOS2_MULT_PIPE_MULX_EN
    if (op == 2'd2 || op == 2'd3) ax = {{32{a[31]}}, a};
    if (op == 2'd3) bx = {{32{b[31]}}, b};
    p = ax * bx;
    return (op == 2'd0) ? p[31:0] : p[63:32];
`else
    p = ax * bx;
    return (op == 2'd0 || op != 2'd0) ? p[31:0] : 32'h0;
`endif
  endfunction

  // out_ready driver: optional temporary stall on top of a base level.
  always @(negedge clk) begin
    if (hold_cnt > 0) begin
      bus.out_ready = 1'b0;
      hold_cnt--;
    end else begin
      bus.out_ready = or_level;
    end
  end

  // Input monitor: checks in_ready against occupancy and pushes accepted ops.
  always begin
    @(negedge clk);
    #3;
    if (reset_n) begin
      check("in_ready", {31'b0, bus.in_ready}, {31'b0, (sb.size() < 2) || bus.out_ready});
      if (bus.in_valid && !bus.in_ready) saw_bp = 1'b1;
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back('{result: cur_exp, tag: bus.in_tag, chk_lat: cur_chk, due: cyc + 2});
        pushed++;
      end
    end
  end

  // Output monitor: holds-while-stalled checks and in-order scoreboard compare.
  bit          prev_stall = 1'b0;
  logic [31:0] prev_res;
  logic [4:0]  prev_tag;
  always begin
    exp_t e;
    @(negedge clk);
    #4;
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", {31'b0, bus.out_valid}, 32'd1);
        check("hold_result", bus.out_result, prev_res);
        check("hold_tag", {27'b0, bus.out_tag}, {27'b0, prev_tag});
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result: got 0x%08h tag %0d, expected no result",
                   bus.out_result, bus.out_tag);
        end else begin
          e = sb.pop_front();
          popped++;
          check("result", bus.out_result, e.result);
          check("tag", {27'b0, bus.out_tag}, {27'b0, e.tag});
          if (e.chk_lat) check("latency_edge", cyc, e.due);
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_res   = bus.out_result;
      prev_tag   = bus.out_tag;
    end
  end

  // Call at a negedge; returns at the negedge after the op is accepted.
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag, input logic [31:0] exp, input bit chk);
    bit acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = tag;
    cur_exp      = exp;
    cur_chk      = chk;
    for (int k = 0; k < 50 && !acc; k++) begin
      #3;
      acc = bus.in_ready;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: tag %0d not accepted within 50 cycles, expected accept", tag);
    end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_op    = 2'd0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    bus.in_tag   = '0;

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_out_result", bus.out_result, 32'd0);
    check("rst_out_tag", {27'b0, bus.out_tag}, 32'd0);
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    @(negedge clk);

    // Directed vectors, back-to-back with out_ready high: each exactly 2 edges.
    foreach (vecs[i]) begin
`ifdef NIOS2_MULT_PIPE_MULX_EN
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].exp_mulx, 1'b1);
`else
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].exp_lo, 1'b1);
`endif
    end
    wait_drain();

    // 16-op stream with a 5-cycle out_ready stall in the middle.
    for (int i = 0; i < 16; i++) begin
      logic [31:0] a, b;
      logic [1:0]  op;
      a  = 32'h9E37_79B9 * (i + 1);
      b  = 32'hDEAD_BEEF - 32'h0101_0101 * i;
      op = 2'(i % 4);
      if (i == 6) hold_cnt = 5;
      send(op, a, b, 5'(i + 8), model(op, a, b), 1'b0);
    end
    wait_drain();
    check("backpressure_seen", {31'b0, saw_bp}, 32'd1);

    // Reset with two ops in flight (out_ready low keeps both stages full).
    or_level = 1'b0;
    @(negedge clk);
    send(2'd0, 32'd7, 32'd9, 5'd1, 32'd63, 1'b0);
    send(2'd0, 32'd11, 32'd13, 5'd2, 32'd143, 1'b0);
    #2;
    reset_n = 1'b0;
    flushed += sb.size();
    sb.delete();
    #1;
    check("mid_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("mid_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    repeat (2) @(negedge clk);
    reset_n  = 1'b1;
    or_level = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_no_stale", {31'b0, bus.out_valid}, 32'd0);
    send(2'd0, 32'h0000_00FF, 32'h0000_0101, 5'd13, 32'h0000_FFFF, 1'b1);
    wait_drain();

    check("result_count", popped, pushed - flushed);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
